// File: rtl/diff_tx_if.sv
// diff_tx_if: fabric-side request/data and status bundle for diff_tx_bank.
interface diff_tx_if #(
    parameter int CHANNELS = 2
) ();
    logic [CHANNELS-1:0] data_in;
    logic [CHANNELS-1:0] oe_req;
    logic [CHANNELS-1:0] driving;
    logic                busy;
    modport master (output data_in, oe_req, input driving, busy);
    modport slave  (input data_in, oe_req, output driving, busy);
endinterface

// File: rtl/diff_tx_bank.sv
// diff_tx_bank: bank of differential tristate pad drivers with synchronised inputs
// and per-channel guarded enable/release sequencing around each OBUFTDS.
module diff_tx_bank #(
    parameter int    CHANNELS     = 2,
    parameter int    GUARD_CYCLES = 2,
    parameter string IOSTANDARD   = "DIFF_SSTL135",
    parameter string SLEW         = "FAST"
) (
    input  logic                clk,
    input  logic                rst_n,
    diff_tx_if.slave            bus,
    output logic [CHANNELS-1:0] diff_p,
    output logic [CHANNELS-1:0] diff_n
);
    typedef enum logic [1:0] {HIZ, ARM, DRIVE, RELEASE} state_t;
    localparam bit         guarded    = GUARD_CYCLES > 0;
    localparam logic [7:0] guard_load = 8'(GUARD_CYCLES - 1);
    logic [CHANNELS-1:0] data_m, data_s, data_q, req_m, req_s, drv, busy_v;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_m <= '0;
            data_s <= '0;
            data_q <= '0;
            req_m  <= '0;
            req_s  <= '0;
        end else begin
            data_m <= bus.data_in;
            data_s <= data_m;
            data_q <= data_s;
            req_m  <= bus.oe_req;
            req_s  <= req_m;
        end
    end
    assign bus.driving = drv;
    assign bus.busy    = |busy_v;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t     state, state_nx;
        logic [7:0] cnt, cnt_nx;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= HIZ;
                cnt   <= '0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
            end
        end
        // RELEASE deliberately ignores req_s so the quiet period always completes
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            case (state)
                HIZ: if (req_s[i]) begin
                    state_nx = guarded ? ARM : DRIVE;
                    cnt_nx   = guarded ? guard_load : cnt;
                end
                ARM: begin
                    state_nx = !req_s[i] ? HIZ : (cnt == '0) ? DRIVE : ARM;
                    cnt_nx   = (req_s[i] && cnt != '0) ? cnt - 8'd1 : cnt;
                end
                DRIVE: if (!req_s[i]) begin
                    state_nx = guarded ? RELEASE : HIZ;
                    cnt_nx   = guarded ? guard_load : cnt;
                end
                RELEASE: begin
                    state_nx = (cnt == '0) ? HIZ : RELEASE;
                    cnt_nx   = (cnt == '0) ? cnt : cnt - 8'd1;
                end
                default: state_nx = HIZ;
            endcase
        end
        assign drv[i]    = state == DRIVE;
        assign busy_v[i] = state == ARM || state == RELEASE;
        OBUFTDS #(
            .IOSTANDARD (IOSTANDARD),
            .SLEW       (SLEW)
        ) u_obuf (
            .O  (diff_p[i]),
            .OB (diff_n[i]),
            .I  (data_q[i]),
            .T  (~drv[i])
        );
    end
endmodule

// Behavioural stand-in for the vendor differential tristate output buffer.
module OBUFTDS #(
    parameter string IOSTANDARD = "DEFAULT",
    parameter string SLEW       = "SLOW"
) (
    output logic O,
    output logic OB,
    input  logic I,
    input  logic T
);
    assign O  = T ? 1'bz : I;
    assign OB = T ? 1'bz : ~I;
endmodule

// File: tb/tb_diff_tx_bank.sv
// tb_diff_tx_bank: three builds (4ch G=2, 2ch G=4, 2ch G=0) checked against a
// timeline model of request latency, guard windows and data latency.
module tb_diff_tx_bank;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    diff_tx_if #(.CHANNELS(4)) if_a ();
    diff_tx_if #(.CHANNELS(2)) if_b ();
    diff_tx_if #(.CHANNELS(2)) if_c ();
    wire [3:0] p_a, n_a;
    wire [1:0] p_b, n_b, p_c, n_c;

    diff_tx_bank #(.CHANNELS(4), .GUARD_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a), .diff_p(p_a), .diff_n(n_a));
    diff_tx_bank #(.CHANNELS(2), .GUARD_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b), .diff_p(p_b), .diff_n(n_b));
    diff_tx_bank #(.CHANNELS(2), .GUARD_CYCLES(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c), .diff_p(p_c), .diff_n(n_c));

    logic [3:0] drv_v[3], p_v[3], n_v[3];
    logic       busy_v[3];
    assign drv_v[0] = if_a.driving;
    assign drv_v[1] = {2'b00, if_b.driving};
    assign drv_v[2] = {2'b00, if_c.driving};
    assign busy_v[0] = if_a.busy;
    assign busy_v[1] = if_b.busy;
    assign busy_v[2] = if_c.busy;
    assign p_v[0] = p_a;
    assign n_v[0] = n_a;
    assign p_v[1] = {2'b00, p_b};
    assign n_v[1] = {2'b00, n_b};
    assign p_v[2] = {2'b00, p_c};
    assign n_v[2] = {2'b00, n_c};

    int tests = 0, fails = 0, edge_n = 0;
    int gval[3] = '{2, 4, 0};
    int nch[3]  = '{4, 2, 2};
    bit on[3][4], pend[3][4];
    int start_at[3][4], quiet_until[3][4];
    logic [3:0] rq[3][$], dq[3][$];
    logic [3:0] exp_q[3], req_in[3], dat_in[3];

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            rq[d].delete();
            dq[d].delete();
            repeat (2) begin
                rq[d].push_back(4'b0);
                dq[d].push_back(4'b0);
            end
            exp_q[d] = 4'b0;
            for (int c = 0; c < 4; c++) begin
                on[d][c] = 0;
                pend[d][c] = 0;
                quiet_until[d][c] = edge_n;
            end
        end
    endtask

    // Requests/data reach the control logic two edges after being sampled.
    task automatic model_edge();
        logic [3:0] r;
        edge_n++;
        for (int d = 0; d < 3; d++) begin
            r = rq[d].pop_front();
            rq[d].push_back(req_in[d]);
            exp_q[d] = dq[d].pop_front();
            dq[d].push_back(dat_in[d]);
            for (int c = 0; c < nch[d]; c++) begin
                if (on[d][c]) begin
                    if (!r[c]) begin
                        on[d][c] = 0;
                        quiet_until[d][c] = edge_n + gval[d];
                    end
                end else if (pend[d][c]) begin
                    if (!r[c]) pend[d][c] = 0;
                    else if (edge_n == start_at[d][c]) begin
                        pend[d][c] = 0;
                        on[d][c] = 1;
                    end
                end else if (edge_n > quiet_until[d][c] && r[c]) begin
                    if (gval[d] == 0) on[d][c] = 1;
                    else begin
                        pend[d][c] = 1;
                        start_at[d][c] = edge_n + gval[d];
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] exp_d;
        logic       exp_b;
        for (int d = 0; d < 3; d++) begin
            exp_d = 4'b0;
            exp_b = 1'b0;
            for (int c = 0; c < nch[d]; c++) begin
                exp_d[c] = on[d][c];
                exp_b |= pend[d][c] || edge_n < quiet_until[d][c];
            end
            chk($sformatf("drv d%0d e%0d", d, edge_n), drv_v[d], exp_d);
            chk($sformatf("busy d%0d e%0d", d, edge_n), {3'b0, busy_v[d]}, {3'b0, exp_b});
            for (int c = 0; c < nch[d]; c++)
                if (on[d][c]) begin
                    chk($sformatf("p d%0d c%0d e%0d", d, c, edge_n), {3'b0, p_v[d][c]}, {3'b0, exp_q[d][c]});
                    chk($sformatf("n d%0d c%0d e%0d", d, c, edge_n), {3'b0, n_v[d][c]}, {3'b0, ~exp_q[d][c]});
                end
        end
    endtask

    task automatic apply();
        if_a.oe_req  = req_in[0];
        if_a.data_in = dat_in[0];
        if_b.oe_req  = req_in[1][1:0];
        if_b.data_in = dat_in[1][1:0];
        if_c.oe_req  = req_in[2][1:0];
        if_c.data_in = dat_in[2][1:0];
    endtask

    task automatic step();
        @(negedge clk);
        rst_n = 1'b1;
        apply();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic check_reset(string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s drv d%0d", tag, d), drv_v[d], 4'b0);
            chk($sformatf("%s busy d%0d", tag, d), {3'b0, busy_v[d]}, 4'b0);
        end
    endtask

    task automatic rst_step();
        @(negedge clk);
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) dat_in[d] = ~dat_in[d];
        apply();
        @(posedge clk);
        #1;
        check_reset("rst");
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            req_in[d] = 4'hf;
            dat_in[d] = 4'h5;
        end
        apply();
        model_reset();
        repeat (3) rst_step();
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 4) chk("ch0 before edge5", {3'b0, drv_v[0][0]}, 4'b0);
            if (k == 5) chk("ch0 at edge5", {3'b0, drv_v[0][0]}, 4'b1);
        end
        for (int d = 0; d < 3; d++) begin
            req_in[d] = 4'h0;
            dat_in[d] = 4'h0;
        end
        repeat (10) step();
        req_in[0] = 4'b0001;
        req_in[1] = 4'b0001;
        req_in[2] = 4'b0001;
        repeat (3) step();
        req_in[1] = 4'b0000;
        repeat (7) step();
        dat_in[0] = 4'b0001;
        repeat (4) step();
        req_in[0] = 4'b0000;
        step();
        req_in[0] = 4'b0001;
        repeat (12) step();
        for (int k = 0; k < 8; k++) begin
            req_in[2][0] = ~req_in[2][0];
            req_in[2][1] = k[1];
            repeat (2) step();
        end
        req_in[0] = 4'b1110;
        repeat (10) step();
        req_in[0] = 4'b1010;
        repeat (10) step();
        repeat (400) begin
            for (int d = 0; d < 3; d++) begin
                for (int c = 0; c < nch[d]; c++)
                    if ($urandom_range(5) == 0) req_in[d][c] = ~req_in[d][c];
                dat_in[d] = 4'($urandom);
            end
            step();
        end
        for (int d = 0; d < 3; d++) req_in[d] = 4'hf;
        repeat (15) step();
        chk("all driving before reset", drv_v[0], 4'hf);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async");
        model_reset();
        repeat (2) rst_step();
        repeat (20) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/diff_tx_bank.md
Name: diff_tx_bank

Overview:
- Parametrised bank of CHANNELS differential tristate output drivers, each built on one OBUFTDS primitive.
- Adds input synchronisation and a registered data path.
- Each channel has its own enable state machine with turnaround guard intervals, so a pin never switches directly between hi-Z and driven without a programmable quiet period.
- Sits between fabric control logic (or board switches) and differential pad pairs.

Parameters:
- CHANNELS, 2: number of differential output pairs (1..32).
- GUARD_CYCLES, 2: hi-Z cycles held on both the enable and the release transition (0..255; 0 = no guard).
- IOSTANDARD, "DIFF_SSTL135": passed to every OBUFTDS.
- SLEW, "FAST": passed to every OBUFTDS.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  CHANNELS  per-channel data; asynchronous to clk.
- oe_req  in  CHANNELS  per-channel drive request, level-sensitive; asynchronous to clk.
- diff_p  out  CHANNELS  OBUFTDS O pins.
- diff_n  out  CHANNELS  OBUFTDS OB pins.
- driving  out  CHANNELS  1 = channel in DRIVE (OBUFTDS T=0).
- busy  out  1  OR over channels of state ARM or RELEASE.

Behaviour:
Reset:
- rst_n low asynchronously clears, for every channel:
  - synchronisers, data_q and guard counter = 0;
  - state = HIZ, T = 1 (pads hi-Z).
- driving = 0, busy = 0. All outputs are registered or decoded from registered state.
- Reset asserted mid-operation forces hi-Z in the same instant, with no guard. Release is synchronous to clk.

Input synchronisation:
- data_in and oe_req each pass through a 2-flop synchroniser per bit: data_s, req_s.

Data path:
- data_q <= data_s every cycle, in every state.
- OBUFTDS I = data_q.
- data_in change to pad change = 3 clk edges when in DRIVE.

Per-channel FSM (states HIZ, ARM, DRIVE, RELEASE; guard counter 8 bits):
- HIZ (T=1):
  - req_s=1 and GUARD_CYCLES>0 -> ARM, cnt <= GUARD_CYCLES-1.
  - req_s=1 and GUARD_CYCLES=0 -> DRIVE.
- ARM (T=1):
  - req_s=0 -> HIZ (abort; no RELEASE).
  - else cnt=0 -> DRIVE.
  - else cnt <= cnt-1.
- DRIVE (T=0, driving=1):
  - req_s=0 and GUARD_CYCLES>0 -> RELEASE, cnt <= GUARD_CYCLES-1.
  - req_s=0 and GUARD_CYCLES=0 -> HIZ.
- RELEASE (T=1):
  - cnt=0 -> HIZ; else cnt <= cnt-1.
  - req_s is ignored; a re-request is honoured only after HIZ is reached.

Timing and combinational decode:
- T = ~(state==DRIVE), registered state decode.
- Hi-Z takes effect on the edge that leaves DRIVE.
- Drive begins on the edge that enters DRIVE.
- With GUARD_CYCLES=G>0, a request asserted and held gives:
  - 2 sync cycles, then 1 cycle to ARM, then G cycles in ARM;
  - driving rises on edge 3+G after the req change.
- Release mirrors this: hi-Z from edge 3 after req drops, back to HIZ after G further cycles.

Channels and guard counter:
- Channels are fully independent; simultaneous requests on any set of channels are processed in parallel.
- Guard counter never wraps; it is only loaded on entry to ARM or RELEASE.

Test Plan:
- Reset: rst_n=0 with oe_req=all 1 and data_in toggling -> driving=0, busy=0, all pads hi-Z; after release, channel 0 reaches DRIVE on edge 5 (G=2).
- Enable/data latency: G=2, oe_req[0] 0->1 held -> busy=1 edges 3-4, driving[0]=1 from edge 5. Then data_in[0] 0->1 -> diff_p[0]=1, diff_n[0]=0 three edges later.
- Release guard: in DRIVE, oe_req[0] 1->0 -> T=1 at edge 3. Re-assert oe_req[0] one cycle later -> state HIZ at edge 5, then ARM, DRIVE at edge 5+1+2.
- ARM abort: oe_req pulse of 3 cycles with G=4 -> channel reaches ARM, returns to HIZ, driving never 1.
- G=0 build: oe_req toggles -> driving follows req_s with 1-cycle delay; busy stays 0.
- Independence: CHANNELS=4, requests on channels 1 and 3 simultaneously, channel 2 released mid-stream -> each channel matches its own single-channel timing; async reset mid-DRIVE -> all T=1 immediately.
